// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencing controller for the 16-bit MIPS datapath: steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  state_t state_q, state_d;
  logic   retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      retired_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
    end
  end

  assign state      = state_q;
  assign instr_done = retire;

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 2'b11;
        state_d   = S_EXEC;
        if (opcode == OP_J || opcode == OP_JAL) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          retire   = 1'b1;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_R: state_d = S_WB;
          OP_ADDI: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            state_d   = S_MEM;
          end
          OP_SLTI: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_BEQ: begin
            alu_op   = 2'b01;
            pc_src   = 2'b01;
            pc_write = zero;
            retire   = 1'b1;
          end
          default: state_d = S_IDLE;  // jumps retire in DECODE and never get here
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) retire = 1'b1;
          else state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_R)  ? 2'b01 : 2'b00;
        mem_to_reg = (opcode == OP_LW) ? 2'b01 : 2'b00;
        retire     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) state_d = run ? S_FETCH : S_IDLE;

    // Reset silences every control, including an access still waiting on memory.
    if (rst) begin
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      reg_write  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm; each instruction is judged by its
// cycle count, per-instruction control activity and retired count.
module tb_multicycle_ctrl_fsm;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst, run, zero, mem_ready;
  logic [2:0]    opcode;
  logic          mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0]    pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic          alu_src_a, reg_write, instr_done;
  logic [CW-1:0] retired_cnt;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;
  int st_log[64];

  multicycle_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int all_ctrl();
    return int'({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done});
  endfunction

  // Reference: zero-wait cycles per instruction plus one per memory wait.
  function automatic int exp_lat(input logic [2:0] op, input int fw, input int dw);
    case (op)
      3'd2, 3'd3: return 2 + fw;
      3'd6:       return 3 + fw;
      3'd4:       return 5 + fw + dw;
      3'd5:       return 4 + fw + dw;
      default:    return 4 + fw;
    endcase
  endfunction

  task automatic do_instr(input logic [2:0] op, input logic z, input int fw,
                          input int dw, input logic r);
    int cyc = 0, n_req = 0, n_we = 0, n_rw = 0, n_pw = 0;
    int fw_left = fw, dw_left = dw;
    int last_dst = 0, last_m2r = 0;
    bit done = 0;
    bit is_mem = (op == 3'd4 || op == 3'd5);
    opcode = op;
    zero   = z;
    run    = r;
    while (!done && cyc < 40) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (mem_req) begin
        if (i_or_d) begin
          if (dw_left == 0) mem_ready = 1'b1; else dw_left--;
        end else begin
          if (fw_left == 0) mem_ready = 1'b1; else fw_left--;
        end
      end
      #1;
      st_log[cyc] = int'(state);
      cyc++;
      n_req += int'(mem_req);
      n_we  += int'(mem_we);
      n_rw  += int'(reg_write);
      n_pw  += int'(pc_write);
      last_dst = int'(reg_dst);
      last_m2r = int'(mem_to_reg);
      done = instr_done;
    end
    check("no_timeout", int'(done), 1);
    check("latency", cyc, exp_lat(op, fw, dw));
    check("mem_req_cycles", n_req, fw + 1 + (is_mem ? dw + 1 : 0));
    check("mem_we_cycles", n_we, (op == 3'd5) ? dw + 1 : 0);
    check("reg_write_cycles", n_rw, (op == 3'd2 || op == 3'd5 || op == 3'd6) ? 0 : 1);
    check("pc_write_cycles", n_pw, 1 + ((op == 3'd2 || op == 3'd3) ? 1 : 0) + ((op == 3'd6 && z) ? 1 : 0));
    check("last_reg_dst", last_dst, (op == 3'd0) ? 1 : (op == 3'd3) ? 2 : 0);
    check("last_mem_to_reg", last_m2r, (op == 3'd4) ? 1 : (op == 3'd3) ? 2 : 0);
    model_cnt = (model_cnt + 1) % (1 << CW);
    @(posedge clk);
    #1;
    check("retired_cnt", int'(retired_cnt), model_cnt);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = 3'd0;

    // Reset held for two edges with run high.
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_cnt", int'(retired_cnt), 0);
    check("rst_ctrl", all_ctrl(), 0);
    rst = 1'b0;
    #1;
    check("idle_ctrl", all_ctrl(), 0);

    // R-type, zero-wait: state walk 1,2,3,5.
    do_instr(3'd0, 1'b0, 0, 0, 1'b1);
    check("r_seq0", st_log[0], 1);
    check("r_seq1", st_log[1], 2);
    check("r_seq2", st_log[2], 3);
    check("r_seq3", st_log[3], 5);

    do_instr(3'd4, 1'b0, 2, 2, 1'b1);   // lw, 9 cycles
    do_instr(3'd6, 1'b1, 0, 0, 1'b1);   // beq taken
    do_instr(3'd6, 1'b0, 0, 0, 1'b1);   // beq not taken
    do_instr(3'd3, 1'b0, 0, 0, 1'b0);   // jal, then stop
    check("jal_decode_state", st_log[1], 2);
    @(negedge clk);
    #1;
    check("idle_after_stop", int'(state), 0);
    check("idle_no_req", int'(mem_req), 0);
    run = 1'b1;

    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    // Reset during a sw data wait.
    opcode = 3'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw_mem_req", int'(mem_req), 1);
    check("sw_mem_we", int'(mem_we), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_req", int'(mem_req), 0);
    check("rstmid_we", int'(mem_we), 0);
    check("rstmid_done", int'(instr_done), 0);
    @(posedge clk);
    #1;
    model_cnt = 0;
    check("rstmid_cnt", int'(retired_cnt), 0);
    check("rstmid_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;

    // Counter wrap: fill with jumps, then one more.
    for (int i = 0; i < (1 << CW) - 1; i++) do_instr(3'd2, 1'b0, 0, 0, 1'b1);
    check("cnt_full", int'(retired_cnt), (1 << CW) - 1);
    do_instr(3'd2, 1'b0, 0, 0, 1'b1);
    check("cnt_wrap", int'(retired_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multi-cycle sequencing controller for the 16-bit MIPS datapath. It replaces single-cycle opcode decoding with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives per-state datapath control and a request/ready handshake to the shared instruction/data memory, and counts retired instructions. It sits beside the datapath and takes `opcode` from the instruction register and `zero` from the ALU.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `run`  in  1: enable instruction issue. Sampled only when leaving IDLE or retiring an instruction.
- `opcode`  in  3: IR[15:13]. Valid from DECODE onward. 000 R, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
- `zero`  in  1: ALU zero flag, sampled in EXEC for beq.
- `mem_ready`  in  1: memory completes the access in a cycle where `mem_req`=1.
- `mem_req`  out  1: memory access request.
- `mem_we`  out  1: write request, asserted only with `mem_req`.
- `i_or_d`  out  1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write`  out  1: load IR (and MDR) from memory data.
- `pc_write`  out  1: PC load enable.
- `pc_src`  out  2: PC source. 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `alu_src_a`  out  1: ALU A input. 0 = PC, 1 = rs.
- `alu_src_b`  out  2: ALU B input. 00 = rt, 01 = const 2, 10 = sext(imm), 11 = sext(imm)<<1.
- `alu_op`  out  2: 00 R-funct, 01 subtract, 10 set-less-than, 11 add.
- `reg_dst`  out  2: destination register. 00 = rt, 01 = rd, 10 = r7.
- `mem_to_reg`  out  2: write-back source. 00 = ALUOut, 01 = MDR, 10 = PC.
- `reg_write`  out  1: register file write enable.
- `instr_done`  out  1: one-cycle pulse on the last cycle of each instruction.
- `retired_cnt`  out  CNT_W: count of retired instructions.
- `state`  out  3: current state. 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB.

## Operation
- All outputs not listed for a state are 0.
- Control outputs are a combinational function of `state`, `opcode`, `zero` and `mem_ready`.
- Every control output is forced to 0 in any cycle where `rst`=1.
- IDLE: no outputs. Go to FETCH if `run`, else stay.
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=11.
  - Holds in FETCH while `mem_ready`=0.
  - In the `mem_ready` cycle: `ir_write`=1, `pc_write`=1, `pc_src`=00, then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=11; the branch target is captured in ALUOut.
  - j: `pc_write`=1, `pc_src`=10, retire.
  - jal: `pc_write`=1, `pc_src`=10, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, retire.
  - Any other opcode: go to EXEC.
- EXEC:
  - R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00, go to WB.
  - addi/lw/sw: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. addi goes to WB; lw/sw go to MEM.
  - slti: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10, go to WB.
  - beq: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `pc_write`=`zero`, retire.
- MEM: `mem_req`=1, `i_or_d`=1, `mem_we`=1 for sw. Holds while `mem_ready`=0.
  - On `mem_ready`, lw: `ir_write`=0 (MDR loads unconditionally), go to WB.
  - On `mem_ready`, sw: retire.
- WB: `reg_write`=1. `reg_dst`=01 for R, 00 otherwise. `mem_to_reg`=01 for lw, 00 otherwise. Retire.
- Retire means:
  - `instr_done`=1 that cycle, and `retired_cnt` increments at the clock edge. It wraps from 2^CNT_W−1 to 0.
  - Next state is FETCH if `run`=1, otherwise IDLE.
- Deasserting `run` never aborts an in-flight instruction.
- Unreachable state encodings (6, 7) go to IDLE on the next edge.

## Timing
- Reset: `state`=IDLE and `retired_cnt`=0 after the first edge with `rst`=1. All outputs read 0 during and after reset until FETCH.
- Reset mid-instruction, including during a memory wait: the access is abandoned, `mem_req` is 0 in the `rst` cycle, and nothing retires.
- Cycles per instruction with zero-wait memory (`mem_ready`=1 throughout):
  - j, jal: 2
  - beq: 3
  - R, addi, slti, sw: 4
  - lw: 5
- Each memory wait cycle adds exactly 1 cycle.
- `mem_req` stays high continuously until `mem_ready`. It deasserts the cycle after acceptance unless the next state also requests.
- IDLE→FETCH takes 1 cycle after `run` rises; the first `mem_req` appears in the cycle after the edge that samples `run`=1.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `run`=1 → `state`=0, `retired_cnt`=0, all controls 0. The first FETCH starts the cycle after `rst` falls.
- R-type, `mem_ready`=1: `state` sequence 1,2,3,5 → WB shows `reg_write`=1, `reg_dst`=01; `instr_done` pulses; `retired_cnt`=1.
- lw with 2 wait cycles on both fetch and data → 9 cycles total; WB shows `mem_to_reg`=01; `mem_we` is never 1.
- beq with `zero`=1 → `pc_write`=1, `pc_src`=01 in EXEC. beq with `zero`=0 → `pc_write`=0. Both retire in 3 cycles.
- jal → DECODE cycle shows `pc_write`=1, `pc_src`=10, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. Then `run`=0 → `state`=IDLE.
- `rst` pulse during a sw MEM wait → `mem_req`/`mem_we` drop, `retired_cnt` clears. With `retired_cnt` preset to 0xFFFF via 65535 j instructions, one more retire → wraps to 0.
